// File: rtl/ltl_report_collector.sv
// Turns rising LTL violation flags into timestamped reports, one per property,
// serialized lowest-index-first into a first-word-fall-through report FIFO.
module ltl_report_collector #(
    parameter int NUM_PROPS = 9,
    parameter int DEPTH     = 8,
    parameter int TS_W      = 16,
    parameter int ID_W      = $clog2(NUM_PROPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [NUM_PROPS-1:0]   ltl_in,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [ID_W-1:0]        rpt_id,
    output logic [TS_W-1:0]        rpt_ts,
    output logic [$clog2(DEPTH):0] rpt_count,
    output logic                   rpt_overflow,
    input  logic                   overflow_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0]      ts_q;
    logic [NUM_PROPS-1:0] prev_q, pend_q, pend_d;
    logic [NUM_PROPS-1:0] ev, clr_vec, collide;
    logic [TS_W-1:0]      pend_ts_q [NUM_PROPS];
    logic [ID_W-1:0]      mem_id_q [DEPTH];
    logic [TS_W-1:0]      mem_ts_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 push, pop, found;
    logic [ID_W-1:0]      sel_id;

    assign ev   = run ? (ltl_in & ~prev_q) : '0;
    assign pop  = (count_q != '0) && rpt_ready;
    // Fullness is judged before the same-cycle pop, so a full FIFO never pushes.
    assign push = (|pend_q) && (count_q < (AW+1)'(DEPTH));

    always_comb begin
        sel_id  = '0;
        clr_vec = '0;
        found   = 1'b0;
        for (int p = 0; p < NUM_PROPS; p++) begin
            if (pend_q[p] && !found) begin
                found      = 1'b1;
                sel_id     = ID_W'(p);
                clr_vec[p] = push;
            end
        end
    end

    // A bit being drained this cycle can take a new event without colliding.
    assign collide = ev & pend_q & ~clr_vec;
    assign pend_d  = (pend_q & ~clr_vec) | ev;
    assign ovf_d   = (|collide) ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q     <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int p = 0; p < NUM_PROPS; p++) pend_ts_q[p] <= '0;
        end else begin
            if (run) ts_q <= ts_q + TS_W'(1);
            prev_q  <= ltl_in;
            pend_q  <= pend_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            for (int p = 0; p < NUM_PROPS; p++) begin
                if (ev[p] && !collide[p]) pend_ts_q[p] <= ts_q;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id_q[wr_ptr_q] <= sel_id;
            mem_ts_q[wr_ptr_q] <= pend_ts_q[sel_id];
        end
    end

    assign rpt_valid    = (count_q != '0);
    assign rpt_id       = rpt_valid ? mem_id_q[rd_ptr_q] : '0;
    assign rpt_ts       = rpt_valid ? mem_ts_q[rd_ptr_q] : '0;
    assign rpt_count    = count_q;
    assign rpt_overflow = ovf_q;
endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed and random stimulus for ltl_report_collector, checked every cycle
// against a queue-based reference model of the report path.
module tb_ltl_report_collector;
    localparam int NP = 9, DEPTH = 8, TS_W = 16, ID_W = 4;

    logic              clk = 1'b0;
    logic              reset, run, rpt_ready, overflow_clr;
    logic [NP-1:0]     ltl_in;
    logic              rpt_valid, rpt_overflow;
    logic [ID_W-1:0]   rpt_id;
    logic [TS_W-1:0]   rpt_ts;
    logic [3:0]        rpt_count;

    int vectors = 0, miscompares = 0;

    ltl_report_collector #(.NUM_PROPS(NP), .DEPTH(DEPTH), .TS_W(TS_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .run(run), .ltl_in(ltl_in),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id),
        .rpt_ts(rpt_ts), .rpt_count(rpt_count), .rpt_overflow(rpt_overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int ts; } rpt_t;
    rpt_t      m_q[$];
    bit        m_pend[NP];
    int        m_pts[NP];
    bit [NP-1:0] m_prev;
    bit        m_ovf;
    int        m_ts;

    task automatic model_reset();
        m_q.delete();
        for (int p = 0; p < NP; p++) begin m_pend[p] = 0; m_pts[p] = 0; end
        m_prev = '0; m_ovf = 0; m_ts = 0;
    endtask

    // One clock edge in terms of reports: pop, push lowest pending, absorb events.
    task automatic model_edge();
        bit pop, push, set_ovf;
        int sel, size0;
        size0 = m_q.size();
        pop = (size0 > 0) && rpt_ready;
        sel = -1;
        for (int p = 0; p < NP; p++) if (m_pend[p] && sel < 0) sel = p;
        push = (sel >= 0) && (size0 < DEPTH);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back('{sel, m_pts[sel]});
            m_pend[sel] = 0;
        end
        set_ovf = 0;
        for (int p = 0; p < NP; p++) begin
            if (run && ltl_in[p] && !m_prev[p]) begin
                if (m_pend[p]) set_ovf = 1;
                else begin m_pend[p] = 1; m_pts[p] = m_ts; end
            end
        end
        if (set_ovf) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
        m_prev = ltl_in;
        if (run) m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(rpt_valid), 32'(m_q.size() > 0));
        chk("count", 32'(rpt_count), 32'(m_q.size()));
        chk("id",    32'(rpt_id),    (m_q.size() > 0) ? 32'(m_q[0].id) : 32'd0);
        chk("ts",    32'(rpt_ts),    (m_q.size() > 0) ? 32'(m_q[0].ts) : 32'd0);
        chk("ovf",   32'(rpt_overflow), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_to_ts(input int target, input int limit);
        int n = 0;
        while (m_ts != target && n < limit) begin step(); n++; end
        if (m_ts != target) begin
            miscompares++;
            $display("FAIL run_to_ts observed=%0h expected=%0h", m_ts, target);
        end
    endtask

    initial begin
        logic [NP-1:0] flip;
        reset = 1'b0; run = 1'b0; ltl_in = '0; rpt_ready = 1'b0; overflow_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rpt_valid), 32'd0);
        chk("rst_count", 32'(rpt_count), 32'd0);
        @(negedge clk) reset = 1'b1;

        // single event at ts=5
        run = 1'b1; rpt_ready = 1'b1;
        run_to_ts(5, 20);
        ltl_in = 9'h004;
        step();
        step();
        chk("single_valid", 32'(rpt_valid), 32'd1);
        chk("single_id",    32'(rpt_id),    32'd2);
        chk("single_ts",    32'(rpt_ts),    32'd5);
        step();
        chk("single_drained", 32'(rpt_count), 32'd0);
        ltl_in = '0; step();

        // simultaneous events at ts=10, reader stalled
        rpt_ready = 1'b0;
        run_to_ts(10, 20);
        ltl_in = 9'h1FF;
        repeat (11) step();
        chk("sim_full",  32'(rpt_count), 32'd8);
        chk("sim_head",  32'(rpt_id),    32'd0);
        chk("sim_ts",    32'(rpt_ts),    32'd10);
        rpt_ready = 1'b1; step();
        chk("sim_pop_no_push", 32'(rpt_count), 32'd7);
        rpt_ready = 1'b0; step();
        chk("sim_id8_in", 32'(rpt_count), 32'd8);
        chk("sim_no_ovf", 32'(rpt_overflow), 32'd0);

        // collision on property 3 while the FIFO is full
        ltl_in = 9'h1F7; step();
        ltl_in = 9'h1FF; step();
        ltl_in = 9'h1F7; step();
        ltl_in = 9'h1FF; step();
        chk("coll_ovf", 32'(rpt_overflow), 32'd1);
        rpt_ready = 1'b1;
        repeat (12) step();
        chk("coll_drained", 32'(rpt_count), 32'd0);
        overflow_clr = 1'b1; step();
        overflow_clr = 1'b0;
        chk("ovf_clr", 32'(rpt_overflow), 32'd0);

        // run gating: flag raised while stopped produces nothing
        ltl_in = '0; step();
        run = 1'b0;
        ltl_in = 9'h002; repeat (3) step();
        run = 1'b1; repeat (3) step();
        chk("gate_none", 32'(rpt_count), 32'd0);
        ltl_in = '0; step();

        // timestamp wrap, then head held under backpressure
        run_to_ts(16'hFFFF, 70000);
        rpt_ready = 1'b0;
        ltl_in = 9'h001; step();
        ltl_in = 9'h003; step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wrap_hold_id", 32'(rpt_id), 32'd0);
            chk("wrap_hold_ts", 32'(rpt_ts), 32'hFFFF);
            step();
        end
        rpt_ready = 1'b1; step();
        chk("wrap_id1", 32'(rpt_id), 32'd1);
        chk("wrap_ts0", 32'(rpt_ts), 32'd0);
        step();
        ltl_in = '0; step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            flip = '0;
            if ($urandom_range(0, 2) == 0) flip[$urandom_range(0, NP-1)] = 1'b1;
            ltl_in       = ltl_in ^ flip;
            run          = ($urandom_range(0, 7) != 0);
            rpt_ready    = ($urandom_range(0, 2) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        // async reset with three reports queued
        run = 1'b1; rpt_ready = 1'b0; overflow_clr = 1'b0; ltl_in = '0;
        repeat (2) step();
        while (m_q.size() != 0) begin rpt_ready = 1'b1; step(); end
        rpt_ready = 1'b0;
        ltl_in = 9'h007;
        repeat (4) step();
        chk("pre_reset_count", 32'(rpt_count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 32'(rpt_valid), 32'd0);
        chk("async_count", 32'(rpt_count), 32'd0);
        model_reset();
        ltl_in = 9'h010;
        @(negedge clk) reset = 1'b1;
        step();
        step();
        chk("post_rst_id", 32'(rpt_id), 32'd4);
        chk("post_rst_ts", 32'(rpt_ts), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
